// File: rtl/bpsk_diff_demod.sv
// bpsk_diff_demod: differential BPSK hard-decision demodulator fed by the
// CORDIC polar stream, with carrier search/lock and symbol-timing resync.
//
// Ports:
//   s00_axis_aclk     sole clock
//   s00_axis_areset   synchronous active-high reset
//   s00_axis_tvalid   input sample valid
//   s00_axis_tlast    last sample of a packet
//   s00_axis_tdata    {angle[15:0], mag[15:0]}
//   s00_axis_tready   sample accepted when tvalid && tready
//   m00_axis_tvalid   bit decision valid
//   m00_axis_tlast    decision came from a tlast sample
//   m00_axis_tdata    {mag[15:0], 15'b0, bit}
//   m00_axis_tready   downstream ready
//   m00_axis_tstrb    constant 4'hf
module bpsk_diff_demod #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int C_SAMPLES_PER_SYMBOL   = 8,
  parameter int C_MAG_THRESH           = 1000,
  parameter int C_SYNC_COUNT           = 4,
  parameter int C_LOSS_COUNT           = 4
) (
  input  logic                              s00_axis_aclk,
  input  logic                              s00_axis_areset,
  input  logic                              s00_axis_tvalid,
  input  logic                              s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0] s00_axis_tdata,
  output logic                              s00_axis_tready,
  output logic                              m00_axis_tvalid,
  output logic                              m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0] m00_axis_tdata,
  input  logic                              m00_axis_tready,
  output logic [3:0]                        m00_axis_tstrb
);

  typedef enum logic {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int CW = $clog2(C_SAMPLES_PER_SYMBOL);
  localparam int SW = $clog2(C_SYNC_COUNT + 1);
  localparam int LW = $clog2(C_LOSS_COUNT + 1);

  localparam logic [CW-1:0] L_MID =
    CW'(C_SAMPLES_PER_SYMBOL / 2);
  localparam logic [SW-1:0] L_SYNC =
    SW'(C_SYNC_COUNT);
  localparam logic [LW-1:0] L_LOSS =
    LW'(C_LOSS_COUNT);
  localparam logic [15:0] L_THRESH =
    16'(C_MAG_THRESH);
  localparam logic [15:0] L_Q1 = 16'd16384;
  localparam logic [15:0] L_Q3 = 16'd49151;

  state_t                      r_state;
  logic [CW-1:0]               r_sample_cnt;
  logic [SW-1:0]               r_sync_cnt;
  logic [LW-1:0]               r_loss_cnt;
  logic [15:0]                 r_prev_angle;
  logic [15:0]                 r_sym_angle;
  logic                        r_first_sym;
  logic                        r_m_tvalid;
  logic                        r_m_tlast;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] r_m_tdata;

  logic [15:0]   w_mag;
  logic [15:0]   w_angle;
  logic          w_accept;
  logic          w_consume;
  logic [15:0]   w_delta;
  logic          w_flip;
  logic [CW-1:0] w_idx;
  logic          w_mid;
  logic [15:0]   w_sd;
  logic          w_bit;
  logic          w_low;
  logic [SW-1:0] w_sync_next;
  logic [LW-1:0] w_loss_next;

  assign w_mag   = s00_axis_tdata[15:0];
  assign w_angle = s00_axis_tdata[31:16];

  assign s00_axis_tready = !r_m_tvalid || m00_axis_tready;
  assign w_accept  = s00_axis_tvalid && s00_axis_tready;
  assign w_consume = r_m_tvalid && m00_axis_tready;

  // 16-bit wrap gives the angle difference modulo 2*pi
  assign w_delta = w_angle - r_prev_angle;
  assign w_flip  = (w_delta >= L_Q1) && (w_delta <= L_Q3);

  // a phase flip marks a symbol boundary: restart timing at index 0
  assign w_idx = w_flip ? '0 : r_sample_cnt;
  assign w_mid = (w_idx == L_MID);

  assign w_sd  = w_angle - r_sym_angle;
  assign w_bit = (w_sd >= L_Q1) && (w_sd <= L_Q3);

  assign w_low       = (w_mag < L_THRESH);
  assign w_sync_next = w_low ? '0 : r_sync_cnt + SW'(1);
  assign w_loss_next = w_low ? r_loss_cnt + LW'(1) : '0;

  assign m00_axis_tvalid = r_m_tvalid;
  assign m00_axis_tlast  = r_m_tlast;
  assign m00_axis_tdata  = r_m_tdata;
  assign m00_axis_tstrb  = 4'hf;

  always_ff @(posedge s00_axis_aclk) begin
    if (s00_axis_areset) begin
      r_state      <= SEARCH;
      r_sample_cnt <= '0;
      r_sync_cnt   <= '0;
      r_loss_cnt   <= '0;
      r_prev_angle <= '0;
      r_sym_angle  <= '0;
      r_first_sym  <= 1'b1;
      r_m_tvalid   <= 1'b0;
      r_m_tlast    <= 1'b0;
      r_m_tdata    <= '0;
    end else begin
      if (w_consume) begin
        r_m_tvalid <= 1'b0;
      end
      if (w_accept) begin
        r_prev_angle <= w_angle;
        unique case (r_state)
          SEARCH: begin
            r_sync_cnt <= w_sync_next;
            if (w_sync_next == L_SYNC) begin
              r_state      <= LOCKED;
              r_sample_cnt <= '0;
              r_loss_cnt   <= '0;
              r_first_sym  <= 1'b1;
            end
          end
          LOCKED: begin
            // power-of-two symbol length: natural wrap is mod N
            r_sample_cnt <= w_idx + CW'(1);
            r_loss_cnt   <= w_loss_next;
            if (w_mid) begin
              r_sym_angle <= w_angle;
              r_first_sym <= 1'b0;
              if (!r_first_sym) begin
                r_m_tvalid <= 1'b1;
                r_m_tlast  <= s00_axis_tlast;
                r_m_tdata  <= C_M00_AXIS_TDATA_WIDTH'(
                  {w_mag, 15'b0, w_bit});
              end
            end
            if ((w_loss_next == L_LOSS) ||
                s00_axis_tlast) begin
              r_state    <= SEARCH;
              r_sync_cnt <= '0;
            end
          end
          default: r_state <= SEARCH;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bpsk_diff_demod.sv
// tb_bpsk_diff_demod: randomized and directed bench for bpsk_diff_demod
// with a queue-based behavioural model of the demodulator.
module tb_bpsk_diff_demod;

  localparam int SPS    = 8;
  localparam int THRESH = 1000;
  localparam int SYNC   = 4;
  localparam int LOSS   = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic [31:0] s_tdata = '0;
  logic        s_tready;
  logic        m_tvalid;
  logic        m_tlast;
  logic [31:0] m_tdata;
  logic        m_tready = 1'b1;
  logic [3:0]  m_tstrb;

  always #5 clk = ~clk;

  bpsk_diff_demod #(
    .C_S00_AXIS_TDATA_WIDTH(32),
    .C_M00_AXIS_TDATA_WIDTH(32),
    .C_SAMPLES_PER_SYMBOL(SPS),
    .C_MAG_THRESH(THRESH),
    .C_SYNC_COUNT(SYNC),
    .C_LOSS_COUNT(LOSS)
  ) dut (
    .s00_axis_aclk(clk),
    .s00_axis_areset(rst),
    .s00_axis_tvalid(s_tvalid),
    .s00_axis_tlast(s_tlast),
    .s00_axis_tdata(s_tdata),
    .s00_axis_tready(s_tready),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tlast(m_tlast),
    .m00_axis_tdata(m_tdata),
    .m00_axis_tready(m_tready),
    .m00_axis_tstrb(m_tstrb)
  );

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;

  beat_t obs_q[$];
  beat_t exp_q[$];
  int    checks = 0;
  int    failures = 0;
  bit    rand_bp = 1'b0;

  // model state
  bit m_locked;
  int m_sync, m_cnt, m_loss, m_prev, m_sym;
  bit m_first;

  function automatic bit in_flip(int a);
    return (a >= 16384) && (a <= 49151);
  endfunction

  function automatic void model_reset();
    m_locked = 0; m_sync = 0; m_cnt = 0;
    m_loss = 0; m_prev = 0; m_sym = 0;
    m_first = 1;
  endfunction

  function automatic void model_step(int ang, int mag, bit last);
    int    d, idx, sd;
    bit    low;
    beat_t b;
    d = (ang - m_prev) & 32'hFFFF;
    m_prev = ang;
    low = (mag < THRESH);
    if (!m_locked) begin
      m_sync = low ? 0 : m_sync + 1;
      if (m_sync == SYNC) begin
        m_locked = 1; m_cnt = 0;
        m_loss = 0; m_first = 1;
      end
      return;
    end
    idx = in_flip(d) ? 0 : m_cnt;
    m_cnt = (idx + 1) % SPS;
    if (idx == SPS / 2) begin
      sd = (ang - m_sym) & 32'hFFFF;
      if (m_first) m_first = 0;
      else begin
        b.last = last;
        b.data = {mag[15:0], 15'b0, in_flip(sd)};
        exp_q.push_back(b);
      end
      m_sym = ang;
    end
    m_loss = low ? m_loss + 1 : 0;
    if (m_loss == LOSS || last) begin
      m_locked = 0; m_sync = 0;
    end
  endfunction

  always @(negedge clk) begin
    beat_t b;
    if (!rst && m_tvalid && m_tready) begin
      b.last = m_tlast;
      b.data = m_tdata;
      obs_q.push_back(b);
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1 m_tready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input int ang, input int mag,
                      input bit last);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = {ang[15:0], mag[15:0]};
    s_tlast  = last;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_tready && n < 200);
    if (!s_tready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: tready=%0b after %0d cycles, want 1",
               s_tready, n);
    end else begin
      model_step(ang, mag, last);
      @(posedge clk);
    end
    #1 s_tvalid = 1'b0;
    s_tlast = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic drain();
    m_tready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic prime(input int ang, input int mag);
    for (int i = 0; i < SYNC + SPS; i++) send(ang, mag, 0);
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_tvalid: got %0b want 0", m_tvalid);
    end
    checks++;
    if (m_tdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_tdata: got %h want 0", m_tdata);
    end
    checks++;
    if (m_tlast !== 1'b0) begin
      failures++;
      $display("FAIL reset_tlast: got %0b want 0", m_tlast);
    end
    checks++;
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_tready: got %0b want 1", s_tready);
    end
    checks++;
    if (m_tstrb !== 4'hf) begin
      failures++;
      $display("FAIL tstrb: got %h want f", m_tstrb);
    end
    m_tready = 1'b0;
    prime(0, 5000);
    for (int i = 0; i < 5; i++) send(32768, 5000, 0);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL pending_before_reset: got %0b want 1", m_tvalid);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b0 || m_tdata !== 32'h0 ||
        s_tready !== 1'b1) begin
      failures++;
      $display("FAIL midreset: tvalid=%0b tdata=%h tready=%0b want 0 0 1",
               m_tvalid, m_tdata, s_tready);
    end
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) send(0, 5000, 0);
    for (int i = 0; i < 9; i++) send(32768, 5000, 0);
    for (int i = 0; i < 8; i++) send(0, 5000, 0);
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].data !== 32'h13880001) begin
      failures++;
      $display("FAIL reacquire: beats=%0d first=%h want 1 13880001",
               obs_q.size(),
               obs_q.size() ? obs_q[0].data : 32'h0);
    end
  endtask

  task automatic test_lock_decode();
    do_reset();
    prime(0, 5000);
    for (int i = 0; i < 16; i++) send(32768, 5000, 0);
    drain();
    checks++;
    if (obs_q.size() != 2) begin
      failures++;
      $display("FAIL decode_count: got %0d want 2", obs_q.size());
    end else begin
      checks++;
      if (obs_q[0] !== {1'b0, 32'h13880001}) begin
        failures++;
        $display("FAIL decode_bit1: got %h want 13880001",
                 obs_q[0].data);
      end
      checks++;
      if (obs_q[1] !== {1'b0, 32'h13880000}) begin
        failures++;
        $display("FAIL decode_bit0: got %h want 13880000",
                 obs_q[1].data);
      end
    end
  endtask

  task automatic test_wrap_boundary();
    int a[5]  = '{65000, 0, 0, 0, 0};
    int b[5]  = '{500, 16384, 16383, 49151, 49152};
    bit eb[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int mag;
    logic [31:0] want;
    for (int i = 0; i < 5; i++) begin
      mag = 1000 + i * 777;
      do_reset();
      prime(a[i], mag);
      for (int k = 0; k < SPS; k++) send(b[i], mag, 0);
      drain();
      want = {mag[15:0], 15'b0, eb[i]};
      checks++;
      if (obs_q.size() != 1 || obs_q[0].data !== want) begin
        failures++;
        $display("FAIL boundary_%0d: beats=%0d data=%h want 1 %h",
                 i, obs_q.size(),
                 obs_q.size() ? obs_q[0].data : 32'h0, want);
      end
    end
  endtask

  task automatic test_resync();
    do_reset();
    prime(0, 5000);
    for (int i = 0; i < 5; i++) send(0, 5000, 0);
    for (int i = 0; i < 4; i++) send(32768, 5000, 0);
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].data !== 32'h13880000) begin
      failures++;
      $display("FAIL resync_early: beats=%0d want 1 (bit0)",
               obs_q.size());
    end
    send(32768, 5000, 0);
    drain();
    checks++;
    if (obs_q.size() != 2 || obs_q[1].data !== 32'h13880001) begin
      failures++;
      $display("FAIL resync_bit: beats=%0d want 2 (second 13880001)",
               obs_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    prime(0, 5000);
    m_tready = 1'b0;
    for (int i = 0; i < 5; i++) send(32768, 5000, 0);
    @(negedge clk);
    checks++;
    if (m_tvalid !== 1'b1 || s_tready !== 1'b0) begin
      failures++;
      $display("FAIL bp_stall: tvalid=%0b tready=%0b want 1 0",
               m_tvalid, s_tready);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (m_tdata !== 32'h13880001 || m_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL bp_hold: tdata=%h tvalid=%0b want 13880001 1",
               m_tdata, m_tvalid);
    end
    @(posedge clk);
    #1 m_tready = 1'b1;
    @(negedge clk);
    checks++;
    if (s_tready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready: got %0b want 1", s_tready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (m_tvalid !== 1'b0 || obs_q.size() != 1) begin
      failures++;
      $display("FAIL bp_consume: tvalid=%0b beats=%0d want 0 1",
               m_tvalid, obs_q.size());
    end
  endtask

  task automatic test_loss_tlast();
    do_reset();
    prime(0, 5000);
    for (int i = 0; i < LOSS; i++) send(0, 500, 0);
    for (int i = 0; i < 12; i++) send(0, 5000, 0);
    drain();
    checks++;
    if (obs_q.size() != 0) begin
      failures++;
      $display("FAIL loss_search: beats=%0d want 0", obs_q.size());
    end
    for (int i = 0; i < SPS; i++) send(0, 5000, 0);
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0].data !== 32'h13880000) begin
      failures++;
      $display("FAIL loss_relock: beats=%0d want 1 (13880000)",
               obs_q.size());
    end
    do_reset();
    prime(0, 5000);
    for (int i = 0; i < 4; i++) send(32768, 5000, 0);
    send(32768, 5000, 1);
    for (int i = 0; i < 12; i++) send(32768, 5000, 0);
    drain();
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== {1'b1, 32'h13880001}) begin
      failures++;
      $display("FAIL tlast_beat: beats=%0d last=%0b want 1 1",
               obs_q.size(), obs_q.size() ? obs_q[0].last : 1'b0);
    end
  endtask

  task automatic test_random();
    int p, ang, mag;
    bit last;
    do_reset();
    rand_bp = 1'b1;
    p = 0;
    for (int k = 0; k < 800; k++) begin
      if (k % SPS == 0 && $urandom_range(0, 1) == 1)
        p = (p + 32768) & 32'hFFFF;
      if ($urandom_range(0, 39) == 0)
        ang = $urandom_range(0, 65535);
      else
        ang = (p + $urandom_range(0, 600) - 300) & 32'hFFFF;
      if ($urandom_range(0, 9) == 0)
        mag = $urandom_range(0, THRESH - 1);
      else
        mag = $urandom_range(THRESH, 20000);
      last = ($urandom_range(0, 99) == 0);
      send(ang, mag, last);
    end
    rand_bp = 1'b0;
    @(posedge clk);
    #2;
    drain();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count: got %0d want %0d",
               obs_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (obs_q[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rand_beat_%0d: got %0b/%h want %0b/%h", i,
                   obs_q[i].last, obs_q[i].data,
                   exp_q[i].last, exp_q[i].data);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock_decode();
    test_wrap_boundary();
    test_resync();
    test_backpressure();
    test_loss_tlast();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
